// File: rtl/rev_pkg.sv
// Shared definitions for the reversible adder / unadder datapath.
//   state_t            : control states of the serial unadder (IDLE, RUN, DONE)
//   REV_WIDTH_DEFAULT  : default operand width
//   maj()              : three-input majority, the carry function of a full adder
package rev_pkg;

    localparam int REV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Majority of three bits: the carry out of a full adder with inputs x, y, z.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/reversible_inverse_cell.sv
// One-bit inverse of a reversible full-adder cell.
// Given the addend bit a, the forward sum bit s and the incoming carry c, it
// recovers the operand bit b and regenerates the carry the forward cell produced.
// Ports:
//   a      in  addend bit
//   s      in  forward sum bit
//   c      in  carry into this bit position
//   b      out recovered operand bit
//   c_next out carry out of this bit position
module reversible_inverse_cell
    import rev_pkg::*;
(
    input  logic a,
    input  logic s,
    input  logic c,
    output logic b,
    output logic c_next
);

    // s = a ^ b ^ c in the forward cell, so b falls out of the same XOR.
    assign b      = s ^ a ^ c;
    // The regenerated carry must match the forward chain for the next bit.
    assign c_next = maj(a, b, c);

endmodule

// File: rtl/reversible_serial_unadder.sv
// Bit-serial inverse of a reversible ripple adder.
// Given addend A, carry-in Cin and the (WIDTH+1)-bit forward sum S, recovers
// operand B one bit per cycle (LSB first) with a single time-multiplexed
// inverse cell. err flags a sum no valid B could have produced.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   request handshake (ready only while idle)
//   a_in, cin_in     addend and forward carry-in
//   s_in             forward sum {Cout, Sum}
//   out_valid/ready  result handshake
//   b_out            recovered operand B (S - A - Cin mod 2^WIDTH)
//   err              final regenerated carry differs from s_in[WIDTH]
//   g_out            per-bit carries, only when REV_UNADDER_GARBAGE_EN is defined
// Configuration macro: REV_UNADDER_GARBAGE_EN exposes the intermediate carries.
module reversible_serial_unadder
    import rev_pkg::*;
#(
    parameter int WIDTH = REV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic             cin_in,
    input  logic [WIDTH:0]   s_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             err
`ifdef REV_UNADDER_GARBAGE_EN
    ,
    output logic [WIDTH-1:0] g_out
`endif
);

    localparam int              IW       = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);

    state_t            state_r;
    logic [IW-1:0]     idx_r;
    logic              c_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH:0]    s_r;
    logic [WIDTH-1:0]  b_r;
    logic              err_r;
    logic              out_valid_r;
    logic              b_s;
    logic              c_next_s;
    logic [WIDTH:0]    b_shift_s;
`ifdef REV_UNADDER_GARBAGE_EN
    logic [WIDTH-1:0]  g_r;
    logic [WIDTH:0]    g_shift_s;
`endif

    // A and S are shifted right each RUN cycle, so the current bit is always at index 0.
    reversible_inverse_cell u_cell (
        .a      (a_r[0]),
        .s      (s_r[0]),
        .c      (c_r),
        .b      (b_s),
        .c_next (c_next_s)
    );

    // Results enter at the MSB and shift down; after WIDTH cycles bit i sits at index i.
    // The extra top bit keeps the expression legal for WIDTH=1.
    assign b_shift_s = {b_s, b_r} >> 1'b1;
`ifdef REV_UNADDER_GARBAGE_EN
    assign g_shift_s = {c_next_s, g_r} >> 1'b1;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            c_r         <= 1'b0;
            a_r         <= '0;
            s_r         <= '0;
            b_r         <= '0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef REV_UNADDER_GARBAGE_EN
            g_r         <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r     <= a_in;
                        s_r     <= s_in;
                        c_r     <= cin_in;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 1'b1;
                    s_r   <= s_r >> 1'b1;
                    c_r   <= c_next_s;
                    b_r   <= b_shift_s[WIDTH-1:0];
`ifdef REV_UNADDER_GARBAGE_EN
                    g_r   <= g_shift_s[WIDTH-1:0];
`endif
                    idx_r <= idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        // On the last bit the original Cout has shifted down to s_r[1].
                        err_r       <= c_next_s ^ s_r[1];
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign b_out     = b_r;
    assign err       = err_r;
`ifdef REV_UNADDER_GARBAGE_EN
    assign g_out     = g_r;
`endif

endmodule

// File: tb/tb_reversible_serial_unadder.sv
// Self-checking bench for reversible_serial_unadder at WIDTH=4.
// Expected results come from plain integer arithmetic on S - A - Cin.
module tb_reversible_serial_unadder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic         cin_in = 1'b0;
    logic [W:0]   s_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] b_out;
    logic         err;
`ifdef REV_UNADDER_GARBAGE_EN
    logic [W-1:0] g_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_b;
    logic         exp_err;
    logic [W-1:0] exp_g;
    logic         exp_live = 1'b0;

    reversible_serial_unadder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .cin_in    (cin_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .err       (err)
`ifdef REV_UNADDER_GARBAGE_EN
        ,
        .g_out     (g_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Reference: B is the difference S - A - Cin reduced mod 2^W; err when it does not fit.
    // Carries are those of the forward add A + B + Cin at each bit position.
    function automatic void model(input int a, input int cin, input int s,
                                  output logic [W-1:0] b, output logic e,
                                  output logic [W-1:0] g);
        int d;
        int bb;
        int mask;
        d  = s - a - cin;
        bb = ((d % 16) + 16) % 16;
        b  = W'(bb);
        e  = (d < 0) || (d > 15);
        for (int i = 0; i < W; i++) begin
            mask = (1 << (i + 1)) - 1;
            g[i] = (((a & mask) + (bb & mask) + cin) >> (i + 1)) & 1;
        end
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("live_expect", {31'd0, exp_live}, 32'd1);
                check("b_out", {28'd0, b_out}, {28'd0, exp_b});
                check("err", {31'd0, err}, {31'd0, exp_err});
                check("in_ready_busy", {31'd0, in_ready}, 32'd0);
`ifdef REV_UNADDER_GARBAGE_EN
                check("g_out", {28'd0, g_out}, {28'd0, exp_g});
`endif
            end
        end
    end

    task automatic run_req(input int a, input int cin, input int s,
                           input bit use_lit, input int lit_b, input int lit_err,
                           input bit use_g, input int lit_g,
                           input int hold, input bit early);
        int n;
        bit seen;
        // wait for the block to be idle
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle_wait", {31'd0, seen}, 32'd1);
        model(a, cin, s, exp_b, exp_err, exp_g);
        exp_live  = 1'b1;
        a_in      = W'(a);
        cin_in    = cin[0];
        s_in      = (W + 1)'(s);
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("latency", seen ? n : 99, W);
        if (use_lit) begin
            check("b_literal", {28'd0, b_out}, lit_b);
            check("err_literal", {31'd0, err}, lit_err);
        end
`ifdef REV_UNADDER_GARBAGE_EN
        if (use_g) check("g_literal", {28'd0, g_out}, lit_g);
`else
        if (use_g && lit_g < 0) check("g_unused", 32'd0, 32'd1);
`endif
        // Stall in DONE with a competing request that must be ignored.
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in     = ~W'(a);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            if (use_lit) check("hold_b", {28'd0, b_out}, lit_b);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_live = 1'b0;
        @(negedge clk);
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_b_out", {28'd0, b_out}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
`ifdef REV_UNADDER_GARBAGE_EN
        check("rst_g_out", {28'd0, g_out}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        run_req(5, 1, 15, 1'b1, 9, 0, 1'b0, 0, 0, 1'b0);
        run_req(15, 1, 31, 1'b1, 15, 0, 1'b1, 15, 0, 1'b0);
        run_req(8, 0, 3, 1'b1, 11, 1, 1'b0, 0, 0, 1'b0);
        run_req(0, 0, 16, 1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
        run_req(3, 1, 16, 1'b1, 12, 0, 1'b0, 0, 0, 1'b1);
        run_req(5, 1, 15, 1'b1, 9, 0, 1'b0, 0, 10, 1'b0);

        // Reset in the middle of RUN.
        a_in = 4'd5; cin_in = 1'b1; s_in = 5'd15; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_live = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_b", {28'd0, b_out}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_ready", {31'd0, in_ready}, 32'd1);
        check("after_rst_valid", {31'd0, out_valid}, 32'd0);
        run_req(3, 0, 7, 1'b1, 4, 0, 1'b0, 0, 0, 1'b0);

        // Exhaustive round trip through the forward sum.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_req(a, c, a + b + c, 1'b1, b, 0, 1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
